// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting, writeback select and retired-instruction counter
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [REG_AW-1:0] rd,
  input  logic              regwrite,
  input  logic              memread,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        funct3,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_valid,
  output logic              load_fault,
  output logic [CNT_W-1:0]  retired_count
);
  logic              regwrite_q;
  logic [DATA_W-1:0] load_data, sel_data;
  logic              fault;
  always_comb begin
    load_data = funct3 == 3'b000 ? {{(DATA_W-8){read_data[7]}}, read_data[7:0]} :
                funct3 == 3'b001 ? {{(DATA_W-16){read_data[15]}}, read_data[15:0]} :
                funct3 == 3'b100 ? {{(DATA_W-8){1'b0}}, read_data[7:0]} :
                funct3 == 3'b101 ? {{(DATA_W-16){1'b0}}, read_data[15:0]} :
                read_data;
    fault     = memread & (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    sel_data  = wb_sel == 2'b01 ? (memread ? load_data : read_data) :
                wb_sel == 2'b10 ? pc_plus4 : alu_result;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      regwrite_q    <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      load_fault    <= 1'b0;
      retired_count <= '0;
    end else if (flush) begin
      wb_valid   <= 1'b0;
      regwrite_q <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      load_fault <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= in_valid;
      regwrite_q    <= regwrite;
      wb_rd         <= rd;
      wb_data       <= sel_data;
      load_fault    <= fault;
      retired_count <= retired_count + CNT_W'(in_valid);
    end
  end
  assign wb_en = wb_valid & regwrite_q & (wb_rd != '0);
endmodule
